// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared encodings for the memory bus arbiter
package mem_bus_arbiter_pkg;

    localparam logic [1:0] SZ_B   = 2'd0;
    localparam logic [1:0] SZ_H   = 2'd1;
    localparam logic [1:0] SZ_W   = 2'd2;
    localparam logic [1:0] IO_SEL = 2'b11;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    typedef enum logic {GNT_I, GNT_D} gnt_t;

    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        return sz == SZ_B ? 3'd1 : sz == SZ_H ? 3'd2 : 3'd4;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the byte-wide memory bus between fetch and load/store
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int IO_SEL_HI = 17
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              io_buffer_full,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              flush,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [31:0]       i_data,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_done,
    output logic [31:0]       d_rdata,
    output logic              busy
);

    state_t            state, state_n;
    gnt_t              gnt, last_gnt;
    logic [2:0]        cnt, nbytes;
    logic [ADDR_W-1:0] addr_q, issue_addr;
    logic [31:0]       wdata_q, data_q;
    logic [7:0]        issue_byte;
    logic [1:0]        bus_k, cap_k;
    logic              wr_q, io_wr, bus_wr, rd_act, cap_v;
    logic              i_ok, d_ok, pick_d, grant, stall, abort, step, more, hold, issue, issue_wr, fin;

    // a requester still holding req during its own done cycle is not a new request
    assign i_ok   = i_req & ~i_done;
    assign d_ok   = d_req & ~d_done;
    assign pick_d = d_ok & (~i_ok | last_gnt == GNT_I);
    assign grant  = state == IDLE & rdy_in & ~flush & (i_ok | d_ok);
    assign stall  = ~rdy_in | (io_wr & io_buffer_full);
    assign abort  = flush & state != IDLE & ~(gnt == GNT_D & wr_q);
    assign step   = state != IDLE & ~stall & ~abort;
    assign more   = cnt != nbytes;
    assign hold   = state == ISSUE & stall & ~abort;
    assign issue  = grant | (step & state == ISSUE & more);
    assign fin    = step & (state == DRAIN | (state == ISSUE & ~more & wr_q));

    assign issue_wr   = grant ? pick_d & d_wr : wr_q;
    assign issue_addr = grant ? (pick_d ? d_addr : i_addr) : addr_q + ADDR_W'(cnt);
    assign issue_byte = ~issue_wr ? 8'h00 : grant ? d_wdata[7:0] : wdata_q[{cnt[1:0], 3'b000} +: 8];

    assign mem_wr  = bus_wr & ~stall;
    assign busy    = state != IDLE;
    assign i_data  = data_q;
    assign d_rdata = data_q;

    always_comb begin
        state_n = state;
        if (grant) state_n = ISSUE;
        else if (abort) state_n = IDLE;
        else if (step && state == DRAIN) state_n = IDLE;
        else if (step && !more) state_n = wr_q ? IDLE : DRAIN;
    end

    always_ff @(posedge clk_in or negedge rst_in)
        if (!rst_in) state <= IDLE;
        else state <= state_n;

    always_ff @(posedge clk_in or negedge rst_in)
        if (!rst_in) begin
            gnt      <= GNT_I;
            last_gnt <= GNT_D;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
            io_wr    <= 1'b0;
            nbytes   <= 3'd0;
            cnt      <= 3'd0;
            mem_a    <= '0;
            mem_dout <= '0;
            bus_wr   <= 1'b0;
            bus_k    <= '0;
            rd_act   <= 1'b0;
            cap_v    <= 1'b0;
            cap_k    <= '0;
            data_q   <= '0;
            i_done   <= 1'b0;
            d_done   <= 1'b0;
        end else begin
            if (grant) begin
                gnt      <= pick_d ? GNT_D : GNT_I;
                last_gnt <= pick_d ? GNT_D : GNT_I;
                addr_q   <= pick_d ? d_addr : i_addr;
                wdata_q  <= d_wdata;
                wr_q     <= pick_d & d_wr;
                io_wr    <= pick_d & d_wr & (d_addr[IO_SEL_HI -: 2] == IO_SEL);
                nbytes   <= pick_d ? size_bytes(d_size) : 3'd4;
            end
            cnt <= grant ? 3'd1 : issue ? cnt + 3'd1 : cnt;
            if (issue) begin
                mem_a    <= issue_addr;
                mem_dout <= issue_byte;
                bus_wr   <= issue_wr;
                bus_k    <= grant ? 2'd0 : cnt[1:0];
            end else if (!hold) begin
                mem_a    <= '0;
                mem_dout <= '0;
                bus_wr   <= 1'b0;
            end
            // read byte on the bus this cycle arrives on mem_din next cycle
            rd_act <= issue & ~issue_wr;
            cap_v  <= rd_act & ~abort;
            cap_k  <= bus_k;
            if (grant) data_q <= '0;
            else if (cap_v) data_q[{cap_k, 3'b000} +: 8] <= mem_din;
            i_done <= fin & (gnt == GNT_I);
            d_done <= fin & (gnt == GNT_D);
        end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed-vector bench for the memory bus arbiter
module tb_mem_bus_arbiter;

    logic        clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1, io_buffer_full = 1'b0, flush = 1'b0;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        i_req = 1'b0, i_done;
    logic [31:0] i_addr = '0, i_data;
    logic        d_req = 1'b0, d_wr = 1'b0, d_done, busy;
    logic [1:0]  d_size = 2'd0;
    logic [31:0] d_addr = '0, d_wdata = '0, d_rdata;
    logic [7:0]  mem [0:65535];
    int          vectors = 0, miscompares = 0, wr_count = 0;

    mem_bus_arbiter dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .io_buffer_full(io_buffer_full),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr), .flush(flush),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_data(i_data),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .busy(busy)
    );

    always #5 clk_in = ~clk_in;

    // byte memory: read data valid the cycle after its address
    always @(posedge clk_in) begin
        mem_din <= mem[mem_a[15:0]];
        if (mem_wr) begin
            mem[mem_a[15:0]] <= mem_dout;
            wr_count <= wr_count + 1;
        end
    end

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic load4(input logic [15:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) mem[a + 16'(i)] = w[8*i +: 8];
    endtask

    task automatic test_reset;
        #2 rst_in = 1'b0;
        #1;
        vectors++;
        if ({mem_a, mem_dout, mem_wr} !== 41'd0) begin
            miscompares++;
            $display("FAIL reset_bus: got a=%h dout=%h wr=%b want all 0", mem_a, mem_dout, mem_wr);
        end
        vectors++;
        if ({i_done, d_done, busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_ctl: got i_done=%b d_done=%b busy=%b want 000", i_done, d_done, busy);
        end
        vectors++;
        if ({i_data, d_rdata} !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_data: got i_data=%h d_rdata=%h want 0", i_data, d_rdata);
        end
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b1;
    endtask

    task automatic test_word_fetch;
        load4(16'h0100, 32'h0000_0513);
        i_req = 1'b1; i_addr = 32'h100;
        for (int c = 1; c <= 7; c++) begin
            tick;
            if (c == 7) i_req = 1'b0;
            if (c <= 4) begin
                vectors++;
                if (mem_a !== 32'h100 + 32'(c - 1)) begin
                    miscompares++;
                    $display("FAIL fetch_addr c%0d: got %h want %h", c, mem_a, 32'h100 + 32'(c - 1));
                end
            end
            vectors++;
            if (mem_wr !== 1'b0) begin
                miscompares++;
                $display("FAIL fetch_wr c%0d: got %b want 0", c, mem_wr);
            end
            vectors++;
            if (i_done !== 1'(c == 6)) begin
                miscompares++;
                $display("FAIL fetch_done c%0d: got %b want %b", c, i_done, c == 6);
            end
            if (c == 6) begin
                vectors++;
                if (i_data !== 32'h0000_0513) begin
                    miscompares++;
                    $display("FAIL fetch_data: got %h want 00000513", i_data);
                end
            end
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL fetch_no_regrant: busy got %b want 0", busy);
        end
    endtask

    task automatic test_tie_after_reset;
        rst_in = 1'b0;
        tick;
        rst_in = 1'b1;
        i_req = 1'b1; i_addr = 32'h0;
        d_req = 1'b1; d_wr = 1'b1; d_size = 2'd0; d_addr = 32'h2000; d_wdata = 32'h0000_0055;
        for (int c = 1; c <= 9; c++) begin
            tick;
            if (c == 7) i_req = 1'b0;
            if (c == 9) d_req = 1'b0;
            if (c == 1) begin
                vectors++;
                if (mem_a !== 32'h0) begin
                    miscompares++;
                    $display("FAIL tie_first c1: mem_a got %h want 00000000 (fetch first)", mem_a);
                end
            end
            vectors++;
            if (i_done !== 1'(c == 6)) begin
                miscompares++;
                $display("FAIL tie_i_done c%0d: got %b want %b", c, i_done, c == 6);
            end
            if (c == 7) begin
                vectors++;
                if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h2000, 8'h55}) begin
                    miscompares++;
                    $display("FAIL tie_store c7: got wr=%b a=%h dout=%h want 1 00002000 55", mem_wr, mem_a, mem_dout);
                end
            end
            vectors++;
            if (d_done !== 1'(c == 8)) begin
                miscompares++;
                $display("FAIL tie_d_done c%0d: got %b want %b", c, d_done, c == 8);
            end
        end
        vectors++;
        if (mem[16'h2000] !== 8'h55) begin
            miscompares++;
            $display("FAIL tie_mem: got %h want 55", mem[16'h2000]);
        end
    endtask

    task automatic test_alternate;
        i_req = 1'b1; i_addr = 32'h100;
        repeat (7) tick;
        i_req = 1'b0;
        tick;
        i_req = 1'b1; i_addr = 32'h100;
        d_req = 1'b1; d_wr = 1'b0; d_size = 2'd0; d_addr = 32'h2000;
        for (int c = 1; c <= 10; c++) begin
            tick;
            if (c == 4) d_req = 1'b0;
            if (c == 10) i_req = 1'b0;
            if (c == 1) begin
                vectors++;
                if (mem_a !== 32'h2000) begin
                    miscompares++;
                    $display("FAIL alt_data_first c1: mem_a got %h want 00002000", mem_a);
                end
            end
            if (c == 3) begin
                vectors++;
                if ({d_done, d_rdata} !== {1'b1, 32'h55}) begin
                    miscompares++;
                    $display("FAIL alt_load c3: got done=%b data=%h want 1 00000055", d_done, d_rdata);
                end
            end
            if (c == 4) begin
                vectors++;
                if (mem_a !== 32'h100) begin
                    miscompares++;
                    $display("FAIL alt_fetch_next c4: mem_a got %h want 00000100", mem_a);
                end
            end
            vectors++;
            if (i_done !== 1'(c == 9)) begin
                miscompares++;
                $display("FAIL alt_i_done c%0d: got %b want %b", c, i_done, c == 9);
            end
        end
    endtask

    task automatic test_wrap;
        mem[16'hFFFE] = 8'hAA; mem[16'hFFFF] = 8'hBB; mem[16'h0000] = 8'hCC; mem[16'h0001] = 8'hDD;
        i_req = 1'b1; i_addr = 32'hFFFF_FFFE;
        for (int c = 1; c <= 7; c++) begin
            tick;
            if (c == 7) i_req = 1'b0;
            if (c <= 4) begin
                vectors++;
                if (mem_a !== 32'hFFFF_FFFE + 32'(c - 1)) begin
                    miscompares++;
                    $display("FAIL wrap_addr c%0d: got %h want %h", c, mem_a, 32'hFFFF_FFFE + 32'(c - 1));
                end
            end
            if (c == 6) begin
                vectors++;
                if ({i_done, i_data} !== {1'b1, 32'hDDCC_BBAA}) begin
                    miscompares++;
                    $display("FAIL wrap_data c6: got done=%b data=%h want 1 ddccbbaa", i_done, i_data);
                end
            end
        end
    endtask

    task automatic test_io_backpressure;
        int w0;
        w0 = wr_count;
        d_req = 1'b1; d_wr = 1'b1; d_size = 2'd0; d_addr = 32'h0003_0000; d_wdata = 32'h41;
        io_buffer_full = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick;
            if (c == 4) io_buffer_full = 1'b0;
            if (c == 6) d_req = 1'b0;
            #1;
            vectors++;
            if (mem_wr !== 1'(c == 4)) begin
                miscompares++;
                $display("FAIL io_wr c%0d: got %b want %b", c, mem_wr, c == 4);
            end
            if (c <= 4) begin
                vectors++;
                if ({mem_a, mem_dout} !== {32'h0003_0000, 8'h41}) begin
                    miscompares++;
                    $display("FAIL io_hold c%0d: got a=%h dout=%h want 00030000 41", c, mem_a, mem_dout);
                end
            end
            vectors++;
            if (d_done !== 1'(c == 5)) begin
                miscompares++;
                $display("FAIL io_done c%0d: got %b want %b", c, d_done, c == 5);
            end
        end
        vectors++;
        if (wr_count - w0 !== 1) begin
            miscompares++;
            $display("FAIL io_count: got %0d writes want 1", wr_count - w0);
        end
    endtask

    task automatic test_flush;
        load4(16'h0400, 32'h1234_5678);
        i_req = 1'b1; i_addr = 32'h200;
        for (int c = 1; c <= 11; c++) begin
            tick;
            if (c == 3) flush = 1'b1;
            if (c == 4) begin flush = 1'b0; i_addr = 32'h400; end
            if (c == 11) i_req = 1'b0;
            if (c == 3) begin
                vectors++;
                if (mem_a !== 32'h202) begin
                    miscompares++;
                    $display("FAIL flush_pre c3: mem_a got %h want 00000202", mem_a);
                end
            end
            if (c == 4) begin
                vectors++;
                if ({busy, mem_a, mem_wr} !== 34'd0) begin
                    miscompares++;
                    $display("FAIL flush_idle c4: got busy=%b a=%h wr=%b want 0 0 0", busy, mem_a, mem_wr);
                end
            end
            if (c == 5) begin
                vectors++;
                if (mem_a !== 32'h400) begin
                    miscompares++;
                    $display("FAIL flush_restart c5: mem_a got %h want 00000400", mem_a);
                end
            end
            vectors++;
            if (i_done !== 1'(c == 10)) begin
                miscompares++;
                $display("FAIL flush_i_done c%0d: got %b want %b", c, i_done, c == 10);
            end
            if (c == 10) begin
                vectors++;
                if (i_data !== 32'h1234_5678) begin
                    miscompares++;
                    $display("FAIL flush_data: got %h want 12345678", i_data);
                end
            end
        end
        d_req = 1'b1; d_wr = 1'b1; d_size = 2'd2; d_addr = 32'h3000; d_wdata = 32'hA1B2_C3D4;
        for (int c = 1; c <= 6; c++) begin
            tick;
            flush = c == 2;
            if (c == 6) d_req = 1'b0;
            if (c <= 4) begin
                vectors++;
                if ({mem_wr, mem_a} !== {1'b1, 32'h3000 + 32'(c - 1)}) begin
                    miscompares++;
                    $display("FAIL flush_store c%0d: got wr=%b a=%h want 1 %h", c, mem_wr, mem_a, 32'h3000 + 32'(c - 1));
                end
            end
            vectors++;
            if (d_done !== 1'(c == 5)) begin
                miscompares++;
                $display("FAIL flush_store_done c%0d: got %b want %b", c, d_done, c == 5);
            end
        end
        vectors++;
        if ({mem[16'h3003], mem[16'h3002], mem[16'h3001], mem[16'h3000]} !== 32'hA1B2_C3D4) begin
            miscompares++;
            $display("FAIL flush_store_mem: got %h%h%h%h want a1b2c3d4",
                     mem[16'h3003], mem[16'h3002], mem[16'h3001], mem[16'h3000]);
        end
    endtask

    task automatic test_pause;
        mem[16'h1000] = 8'hEF; mem[16'h1001] = 8'hBE;
        d_req = 1'b1; d_wr = 1'b0; d_size = 2'd1; d_addr = 32'h1000;
        for (int c = 1; c <= 7; c++) begin
            tick;
            rdy_in = !(c == 2 || c == 3);
            if (c == 7) d_req = 1'b0;
            #1;
            if (c >= 2 && c <= 4) begin
                vectors++;
                if ({mem_a, mem_wr} !== {32'h1001, 1'b0}) begin
                    miscompares++;
                    $display("FAIL pause_hold c%0d: got a=%h wr=%b want 00001001 0", c, mem_a, mem_wr);
                end
            end
            vectors++;
            if (d_done !== 1'(c == 6)) begin
                miscompares++;
                $display("FAIL pause_done c%0d: got %b want %b", c, d_done, c == 6);
            end
            if (c == 6) begin
                vectors++;
                if (d_rdata !== 32'h0000_BEEF) begin
                    miscompares++;
                    $display("FAIL pause_data: got %h want 0000beef", d_rdata);
                end
            end
        end
    endtask

    task automatic test_async_reset;
        d_req = 1'b1; d_wr = 1'b1; d_size = 2'd2; d_addr = 32'h3100; d_wdata = 32'h1122_3344;
        repeat (2) tick;
        vectors++;
        if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h3101, 8'h33}) begin
            miscompares++;
            $display("FAIL arst_pre: got wr=%b a=%h dout=%h want 1 00003101 33", mem_wr, mem_a, mem_dout);
        end
        #2 rst_in = 1'b0;
        #1;
        vectors++;
        if ({mem_wr, mem_a, d_done, i_done, busy} !== 36'd0) begin
            miscompares++;
            $display("FAIL arst_now: got wr=%b a=%h d_done=%b i_done=%b busy=%b want all 0",
                     mem_wr, mem_a, d_done, i_done, busy);
        end
        d_req = 1'b0; d_wr = 1'b0;
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b1;
        i_req = 1'b1; i_addr = 32'h100;
        for (int c = 1; c <= 7; c++) begin
            tick;
            if (c == 7) i_req = 1'b0;
            if (c == 1) begin
                vectors++;
                if (mem_a !== 32'h100) begin
                    miscompares++;
                    $display("FAIL arst_restart c1: mem_a got %h want 00000100", mem_a);
                end
            end
            if (c == 6) begin
                vectors++;
                if ({i_done, i_data} !== {1'b1, 32'h0000_0513}) begin
                    miscompares++;
                    $display("FAIL arst_fetch c6: got done=%b data=%h want 1 00000513", i_done, i_data);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        test_reset;
        test_word_fetch;
        test_tie_after_reset;
        test_alternate;
        test_wrap;
        test_io_backpressure;
        test_flush;
        test_pause;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
